tour_cmd_seq: RTL
=================

# tour_cmd_seq

Tour command sequencer sitting between the tour solver and the command processor. After the solver pulses its solution-complete strobe, the block walks the 24 stored one-hot knight moves and reads each one through a move-index port. It splits every move into a vertical command followed by a horizontal command and hands each command to the command processor with a ready/clear handshake. It waits for motion completion before issuing the next command. When no tour is in progress, it transparently forwards UART commands to the command processor.

## Interface
- No parameters. Number of moves fixed at 24; command encoding fixed as below.
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- start_tour  in  1  one-cycle pulse from solver "done"; begins playback
- move  in  8  one-hot move read from solver at address mv_indx
- mv_indx  out  5  index of move currently being played (0..23)
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  clear to UART wrapper
- cmd  out  16  command to command processor
- cmd_rdy  out  1  command valid to command processor
- clr_cmd_rdy  in  1  command processor has accepted cmd
- send_resp  in  1  one-cycle pulse: command processor finished a command
- resp  out  8  response byte: 8'hA5 when idle/tour complete, 8'h5A while tour active

## Operation
- Command format: cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] squares.
- Opcodes: 4'h2 = move; 4'h3 = move with fanfare.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Move decode (bit: dx,dy): 0:(-1,+2) 1:(+1,+2) 2:(-2,+1) 3:(-2,-1) 4:(-1,-2) 5:(+1,-2) 6:(+2,-1) 7:(+2,+1).
- Vertical command: opcode 4'h2; heading north if dy>0, else south; squares = |dy|.
- Horizontal command: opcode 4'h3; heading east if dx>0, else west; squares = |dx|.
- Multi-hot move: the lowest set bit wins.
- move == 8'h00: tour aborted; return to IDLE with no command issued.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: mux selects UART path, so cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. On start_tour: mv_indx<=0, go to VERT.
  - VERT: cmd=vertical command, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_V. If move==0, go to IDLE.
  - WAIT_V: cmd_rdy=0, cmd held. On send_resp, go to HORZ.
  - HORZ: cmd=horizontal command, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_H.
  - WAIT_H: on send_resp, if mv_indx==23 go to IDLE (mv_indx holds); else mv_indx<=mv_indx+1 and go to VERT.
- Outside IDLE: clr_cmd_rdy_UART=0 and UART commands are not forwarded. cmd_rdy_UART is ignored and not lost; it is forwarded once the block returns to IDLE.
- start_tour outside IDLE is ignored.
- send_resp in VERT/HORZ/IDLE causes no state change.
- clr_cmd_rdy in WAIT_V/WAIT_H is ignored.
- resp = 8'h5A in any non-IDLE state; 8'hA5 in IDLE. Combinational from state.

## Timing
- Reset: state=IDLE, mv_indx=0. Outputs follow the UART passthrough: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- All outputs are combinational from state, mv_indx and move; no output registers.
- start_tour at edge N: VERT from N+1, with cmd_rdy=1 and cmd valid in the same cycle.
- mv_indx is stable from entry to VERT until the final send_resp of that move. The solver read path is combinational, so move is valid in the same cycle.
- clr_cmd_rdy sampled high at edge N: cmd_rdy low from N+1.
- send_resp in WAIT_H at edge N: next VERT command presented from N+1. Minimum is 2 cycles per command plus processor latency.
- Tour completion: IDLE entered on the edge of the 48th send_resp; resp becomes 8'hA5 the following cycle.
- rst_n asserted mid-tour: immediate return to IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART. No partial command is retained.

## Test plan
- Idle passthrough: cmd_UART=16'h2305, cmd_rdy_UART=1 -> cmd=16'h2305, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1; resp=8'hA5.
- Single move bit1 (+1,+2) at indx 0: start_tour -> cmd=16'h2002, handshake; after send_resp -> cmd=16'h3BF1; resp=8'h5A throughout.
- Move bit3 (-2,-1): vertical 16'h27F1, then horizontal 16'h33F2. Move bit6 (+2,-1): 16'h27F1, then 16'h3BF2.
- Full 24-move tour with a model processor: exactly 48 commands; mv_indx steps 0..23 and holds at 23; IDLE after the 48th send_resp; resp=8'hA5; start_tour pulsed mid-tour is ignored.
- Boundaries: move=8'h00 at indx 5 -> IDLE with no command issued. Move 8'h21 -> decoded as bit0 (16'h2002, 16'h33F1). cmd_rdy_UART=1 during tour -> not forwarded until IDLE.
- Async reset asserted in WAIT_V -> same cycle: cmd_rdy=cmd_rdy_UART, resp=8'hA5, mv_indx=0; next start_tour replays from indx 0.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: plays the solver's 24 knight moves as vertical/horizontal
// command pairs to the command processor, and passes UART commands through when idle.
module tour_cmd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam int unsigned IDX_W    = 5;
    localparam int unsigned LAST_IDX = 23;

    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_FANFARE  = 4'h3;
    localparam logic [7:0] HEAD_NORTH  = 8'h00;
    localparam logic [7:0] HEAD_WEST   = 8'h3F;
    localparam logic [7:0] HEAD_SOUTH  = 8'h7F;
    localparam logic [7:0] HEAD_EAST   = 8'hBF;
    localparam logic [7:0] RESP_IDLE   = 8'hA5;
    localparam logic [7:0] RESP_BUSY   = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] mv_indx_q, mv_indx_d;

    logic        dy_pos, dx_pos;
    logic [1:0]  dy_mag, dx_mag;
    logic [15:0] vert_cmd, horz_cmd;

    // Knight move decode; lowest set bit wins on a multi-hot move
    always_comb begin
        dy_pos = 1'b0;
        dx_pos = 1'b0;
        dy_mag = 2'd0;
        dx_mag = 2'd0;
        casez (move)
            8'b???????1: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
            8'b??????10: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b1; dy_mag = 2'd2; end
            8'b?????100: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
            8'b????1000: begin dx_pos = 1'b0; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
            8'b???10000: begin dx_pos = 1'b0; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
            8'b??100000: begin dx_pos = 1'b1; dx_mag = 2'd1; dy_pos = 1'b0; dy_mag = 2'd2; end
            8'b?1000000: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b0; dy_mag = 2'd1; end
            8'b10000000: begin dx_pos = 1'b1; dx_mag = 2'd2; dy_pos = 1'b1; dy_mag = 2'd1; end
            default: ;
        endcase
    end

    assign vert_cmd = {OP_MOVE,    (dy_pos ? HEAD_NORTH : HEAD_SOUTH), 2'b00, dy_mag};
    assign horz_cmd = {OP_FANFARE, (dx_pos ? HEAD_EAST  : HEAD_WEST),  2'b00, dx_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Next state, move index and the command mux
    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_IDLE;
                if (start_tour) begin
                    mv_indx_d = '0;
                    state_d   = VERT;
                end
            end
            VERT: begin
                // An empty move aborts the tour before anything is offered
                if (move == 8'h00) begin
                    state_d = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) state_d = WAIT_V;
                end
            end
            WAIT_V: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (send_resp) begin
                    if (mv_indx_q == IDX_W'(LAST_IDX)) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + IDX_W'(1);
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule
